// File: rtl/seq_code_lock.sv
// seq_code_lock: N-step push-button combination lock.
// Two raw buttons are synchronised and edge-detected. An inc edge steps the
// current digit and an ok edge confirms it against the code word. A correct
// sequence opens the lock. MAX_FAILS wrong attempts put the lock into a timed
// lockout.
// Optional build macro SEQ_LOCK_TIMEOUT_EN adds an idle timeout. When it fires,
// a partial entry is aborted without counting as a failure.
module seq_code_lock #(
    parameter int unsigned NUM_STEPS      = 6,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned DIGIT_MAX      = 9,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push_inc,
    input  logic                              push_ok,
    input  logic [NUM_STEPS*DIGIT_W-1:0]      code,
    output logic [DIGIT_W-1:0]                digit_val,
    output logic [$clog2(NUM_STEPS)-1:0]      step_idx,
    output logic                              unlock,
    output logic                              fail,
    output logic                              locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt
);

    localparam int unsigned STEP_W = $clog2(NUM_STEPS);
    localparam int unsigned CNT_W  = $clog2(MAX_FAILS + 1);
    localparam int unsigned LK_W   = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DIGIT_W-1:0]  digit_q, digit_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                err_q, err_d;
    logic                fail_q, fail_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic [LK_W-1:0]     lock_cnt_q, lock_cnt_d;

    logic inc_s1_q, inc_s2_q, inc_dl_q;
    logic ok_s1_q, ok_s2_q, ok_dl_q;
    logic inc_edge, ok_edge;
    logic [DIGIT_W-1:0] code_dig;
    logic timeout_abort;

    // Two-flop synchronisers plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_s1_q <= 1'b0;
            inc_s2_q <= 1'b0;
            inc_dl_q <= 1'b0;
            ok_s1_q  <= 1'b0;
            ok_s2_q  <= 1'b0;
            ok_dl_q  <= 1'b0;
        end else begin
            inc_s1_q <= push_inc;
            inc_s2_q <= inc_s1_q;
            inc_dl_q <= inc_s2_q;
            ok_s1_q  <= push_ok;
            ok_s2_q  <= ok_s1_q;
            ok_dl_q  <= ok_s2_q;
        end
    end

    assign inc_edge = inc_s2_q & ~inc_dl_q;
    assign ok_edge  = ok_s2_q & ~ok_dl_q;
    assign code_dig = code[step_q * DIGIT_W +: DIGIT_W];

`ifdef SEQ_LOCK_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_q, idle_d;
    logic            idle_run;

    assign idle_run = (state_q == ST_ENTRY) && !inc_edge && !ok_edge &&
                      ((step_q != '0) || (digit_q != '0));
    assign timeout_abort = idle_run && (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: advances only while a partial entry sits untouched.
    always_comb begin
        idle_d = '0;
        if (idle_run) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_abort = 1'b0;
`endif

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ENTRY;
            digit_q    <= '0;
            step_q     <= '0;
            err_q      <= 1'b0;
            fail_q     <= 1'b0;
            fail_cnt_q <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            step_q     <= step_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            fail_cnt_q <= fail_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state logic. When both edges arrive together, ok takes priority.
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        step_d     = step_q;
        err_d      = err_q;
        fail_d     = 1'b0;
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_ENTRY: begin
                if (ok_edge) begin
                    if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                        if (!err_q && (digit_q == code_dig)) begin
                            state_d    = ST_OPEN;
                            fail_cnt_d = '0;
                        end else begin
                            fail_d  = 1'b1;
                            step_d  = '0;
                            digit_d = '0;
                            err_d   = 1'b0;
                            if (fail_cnt_q != CNT_W'(MAX_FAILS)) begin
                                fail_cnt_d = fail_cnt_q + 1'b1;
                            end
                            if (fail_cnt_d == CNT_W'(MAX_FAILS)) begin
                                state_d    = ST_LOCKOUT;
                                lock_cnt_d = '0;
                            end
                        end
                    end else begin
                        if (digit_q != code_dig) begin
                            err_d = 1'b1;
                        end
                        step_d  = step_q + 1'b1;
                        digit_d = '0;
                    end
                end else if (inc_edge) begin
                    if (digit_q == DIGIT_W'(DIGIT_MAX)) begin
                        digit_d = '0;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end else if (timeout_abort) begin
                    step_d  = '0;
                    digit_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_OPEN: begin
                if (ok_edge) begin
                    state_d = ST_ENTRY;
                    step_d  = '0;
                    digit_d = '0;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == LK_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d    = ST_ENTRY;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    assign digit_val  = digit_q;
    assign step_idx   = step_q;
    assign unlock     = (state_q == ST_OPEN);
    assign fail       = fail_q;
    assign locked_out = (state_q == ST_LOCKOUT);
    assign fail_cnt   = fail_cnt_q;

endmodule
